// File: rtl/imem_boot_loader.sv
// UART-fed boot loader: assembles little-endian words into instruction memory and
// holds the core until the image is complete. Optional checksum byte: BOOT_CHECKSUM_EN.
module imem_boot_loader #(
  parameter int INS_ADDRESS = 9,
  parameter int INS_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_start,
  input  logic                   boot_skip,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic                   imem_we,
  output logic [INS_ADDRESS-3:0] imem_wa,
  output logic [INS_W-1:0]       imem_wd,
  output logic                   cpu_hold,
  output logic                   busy,
  output logic                   err,
  output logic [INS_ADDRESS-2:0] words_loaded
);

  localparam int WA_W  = INS_ADDRESS - 2;
  localparam int WL_W  = INS_ADDRESS - 1;
  localparam int DEPTH = 1 << WA_W;

`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_WRITE, S_CHK, S_RUN, S_ERR} state_e;
  localparam state_e S_DONE = S_CHK;
`else
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_WRITE, S_RUN, S_ERR} state_e;
  localparam state_e S_DONE = S_RUN;
`endif

  state_e            state_q, state_d;
  logic [WL_W-1:0]   n_q;
  logic [WL_W-1:0]   wl_q;
  logic [1:0]        byte_cnt_q;
  logic [23:0]       shift_q;
  logic [WA_W-1:0]   wa_q;
  logic [INS_W-1:0]  wd_q;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic rx_fire;
  logic hdr_too_big;
  logic last_word;

  // NOTE: rx_valid only reaches next-state and datapath logic; every output below
  // is a state decode or a register, so there is no rx_valid-to-output path.
  assign rx_fire     = rx_valid & rx_ready;
  assign hdr_too_big = {24'd0, rx_data} > 32'(DEPTH);
  assign last_word   = (wl_q + WL_W'(1)) == n_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (load_start)     state_d = S_HDR;
        else if (boot_skip) state_d = S_RUN;
      end
      S_HDR: begin
        if (rx_fire) begin
          if (hdr_too_big)          state_d = S_ERR;
          else if (rx_data == 8'd0) state_d = S_DONE;
          else                      state_d = S_DATA;
        end
      end
      S_DATA:  if (rx_fire && byte_cnt_q == 2'd3) state_d = S_WRITE;
      S_WRITE: state_d = last_word ? S_DONE : S_DATA;
`ifdef BOOT_CHECKSUM_EN
      S_CHK:   if (rx_fire) state_d = (rx_data == csum_q) ? S_RUN : S_ERR;
`endif
      S_RUN, S_ERR: if (load_start) state_d = S_HDR;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ready = 1'b0;
    busy     = 1'b0;
    cpu_hold = 1'b1;
    err      = 1'b0;
    imem_we  = 1'b0;
    case (state_q)
      S_HDR, S_DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
`ifdef BOOT_CHECKSUM_EN
      S_CHK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      S_WRITE: begin
        busy    = 1'b1;
        imem_we = 1'b1;
      end
      S_RUN:   cpu_hold = 1'b0;
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  // Write address/data are captured on the fourth byte so they stay put outside WRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q        <= '0;
      wl_q       <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      wa_q       <= '0;
      wd_q       <= '0;
`ifdef BOOT_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_HDR: begin
          if (rx_fire) begin
            n_q        <= WL_W'(rx_data);
            wl_q       <= '0;
            byte_cnt_q <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum_q     <= '0;
`endif
          end
        end
        S_DATA: begin
          if (rx_fire) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            shift_q    <= {rx_data, shift_q[23:8]};
`ifdef BOOT_CHECKSUM_EN
            csum_q     <= csum_q ^ rx_data;
`endif
            if (byte_cnt_q == 2'd3) begin
              wd_q <= {rx_data, shift_q};
              wa_q <= wl_q[WA_W-1:0];
            end
          end
        end
        S_WRITE: wl_q <= wl_q + WL_W'(1);
        default: ;
      endcase
    end
  end

  assign imem_wa      = wa_q;
  assign imem_wd      = wd_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader; covers checksum steps when BOOT_CHECKSUM_EN is defined.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst, load_start, boot_skip, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, imem_we, cpu_hold, busy, err;
  logic [6:0]  imem_wa;
  logic [31:0] imem_wd;
  logic [7:0]  words_loaded;

  int          checks = 0;
  int          errors = 0;
  logic [6:0]  wr_wa[$];
  logic [31:0] wr_wd[$];
  logic [7:0]  xsum;

  always #5 clk = ~clk;

  imem_boot_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start), .boot_skip(boot_skip),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_wa(imem_wa), .imem_wd(imem_wd),
    .cpu_hold(cpu_hold), .busy(busy), .err(err), .words_loaded(words_loaded)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Record every write strobe; the loader must never offer rx_ready while writing.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_wa.push_back(imem_wa);
      wr_wd.push_back(imem_wd);
      check("rx_ready_in_write", 32'(rx_ready), 32'd0);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("rx_accept_timeout", 32'(rx_ready), 32'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      xsum = xsum ^ w[8*i +: 8];
      if (gap) tick();
    end
  endtask

  task automatic finish_load();
`ifdef BOOT_CHECKSUM_EN
    send_byte(xsum);
`else
    tick();
`endif
  endtask

  task automatic pulse_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic clear_log();
    wr_wa.delete();
    wr_wd.delete();
  endtask

  // Two-word image from the bring-up program; expects to start in RUN/ERR/IDLE.
  task automatic load_image(input bit gap);
    clear_log();
    pulse_load();
    check("hdr_busy", 32'(busy), 32'd1);
    check("hdr_hold", 32'(cpu_hold), 32'd1);
    xsum = 8'h00;
    send_byte(8'h02);
    if (gap) tick();
    send_word(32'h0000_7033, gap);
    send_word(32'h0050_0293, 1'b0);
    check("we_latency", 32'(imem_we), 32'd1);
    finish_load();
    check("img_hold", 32'(cpu_hold), 32'd0);
    check("img_busy", 32'(busy), 32'd0);
    check("img_err", 32'(err), 32'd0);
    check("img_words", 32'(words_loaded), 32'd2);
    check("img_nwr", 32'(wr_wa.size()), 32'd2);
    check("img_wa0", 32'(wr_wa[0]), 32'd0);
    check("img_wd0", wr_wd[0], 32'h0000_7033);
    check("img_wa1", 32'(wr_wa[1]), 32'd1);
    check("img_wd1", wr_wd[1], 32'h0050_0293);
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b = 8'(i);
    return {b, b ^ 8'h5A, 8'hFF - b, b + 8'd1};
  endfunction

  initial begin
    rst = 1'b1; load_start = 1'b0; boot_skip = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    xsum = 8'h00;
    tick();
    tick();
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_ready", 32'(rx_ready), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_wa", 32'(imem_wa), 32'd0);
    check("rst_wd", imem_wd, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("idle_hold", 32'(cpu_hold), 32'd1);
    check("idle_err", 32'(err), 32'd0);
    check("idle_nwr", 32'(wr_wa.size()), 32'd0);

    boot_skip = 1'b1;
    tick();
    boot_skip = 1'b0;
    check("skip_hold", 32'(cpu_hold), 32'd0);
    check("skip_busy", 32'(busy), 32'd0);

    load_image(1'b0);
    load_image(1'b1);

    // Oversized header
    clear_log();
    pulse_load();
    send_byte(8'h81);
    check("big_err", 32'(err), 32'd1);
    check("big_hold", 32'(cpu_hold), 32'd1);
    check("big_busy", 32'(busy), 32'd0);
    check("big_words", 32'(words_loaded), 32'd0);
    boot_skip = 1'b1;
    tick();
    boot_skip = 1'b0;
    tick();
    check("err_sticky", 32'(err), 32'd1);
    check("err_skip_hold", 32'(cpu_hold), 32'd1);
    check("big_nwr", 32'(wr_wa.size()), 32'd0);
    load_image(1'b0);

    // Empty image
    clear_log();
    pulse_load();
    xsum = 8'h00;
    send_byte(8'h00);
`ifdef BOOT_CHECKSUM_EN
    check("n0_chk_hold", 32'(cpu_hold), 32'd1);
    send_byte(8'h00);
`endif
    check("n0_hold", 32'(cpu_hold), 32'd0);
    check("n0_words", 32'(words_loaded), 32'd0);
    check("n0_nwr", 32'(wr_wa.size()), 32'd0);

    // Full-depth image
    clear_log();
    pulse_load();
    xsum = 8'h00;
    send_byte(8'h80);
    for (int i = 0; i < 128; i++) send_word(pat(i), 1'b0);
    finish_load();
    check("full_hold", 32'(cpu_hold), 32'd0);
    check("full_err", 32'(err), 32'd0);
    check("full_words", 32'(words_loaded), 32'd128);
    check("full_nwr", 32'(wr_wa.size()), 32'd128);
    for (int i = 0; i < 128; i++) begin
      check("full_wa", 32'(wr_wa[i]), 32'(i));
      check("full_wd", wr_wd[i], pat(i));
    end

`ifdef BOOT_CHECKSUM_EN
    clear_log();
    pulse_load();
    send_byte(8'h01);
    send_word(32'h0000_0013, 1'b0);
    send_byte(8'h12);
    check("csum_bad_err", 32'(err), 32'd1);
    check("csum_bad_hold", 32'(cpu_hold), 32'd1);
    check("csum_bad_nwr", 32'(wr_wa.size()), 32'd1);
    check("csum_bad_wd", wr_wd[0], 32'h0000_0013);
    pulse_load();
    send_byte(8'h01);
    send_word(32'h0000_0013, 1'b0);
    send_byte(8'h13);
    check("csum_ok_hold", 32'(cpu_hold), 32'd0);
    check("csum_ok_err", 32'(err), 32'd0);
`endif

    // Reset in the middle of a word
    clear_log();
    pulse_load();
    send_byte(8'h02);
    send_byte(8'h33);
    send_byte(8'h70);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_hold", 32'(cpu_hold), 32'd1);
    check("mid_ready", 32'(rx_ready), 32'd0);
    check("mid_wa", 32'(imem_wa), 32'd0);
    check("mid_words", 32'(words_loaded), 32'd0);
    repeat (3) tick();
    check("mid_nwr", 32'(wr_wa.size()), 32'd0);

    // load_start beats boot_skip in IDLE
    load_start = 1'b1;
    boot_skip  = 1'b1;
    tick();
    load_start = 1'b0;
    boot_skip  = 1'b0;
    check("both_busy", 32'(busy), 32'd1);
    check("both_ready", 32'(rx_ready), 32'd1);
    send_byte(8'h00);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h00);
`endif
    check("run_hold", 32'(cpu_hold), 32'd0);
    pulse_load();
    check("reload_hold", 32'(cpu_hold), 32'd1);
    check("reload_busy", 32'(busy), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
